// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit_addsub33.sv
// The single 33-bit adder/subtractor shared by every arithmetic step of the unit.
module addsub33 (
  input  logic [32:0] x,
  input  logic [32:0] y,
  input  logic        sub,
  output logic [32:0] sum
);
  assign sum = x + (sub ? ~y : y) + {32'd0, sub};
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M sequencer: 32-step shift-add multiply / restoring divide on one adder.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  muldiv_if.slave  bus
);

  state_t          state;
  logic [4:0]      cnt;
  logic [XLEN-1:0] hi;   // product high half, or remainder
  logic [XLEN-1:0] lo;   // product low half, or quotient
  logic [XLEN-1:0] bm;
  logic [2:0]      op_q;
  logic            neg;

  logic [32:0]     add_x;
  logic [32:0]     add_y;
  logic [32:0]     add_sum;
  logic            add_sub;

  logic            mul_high;
  logic [XLEN-1:0] fix_raw;
  logic [32:0]     mul_acc;

  logic            a_signed;
  logic            b_signed;
  logic            neg_next;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] forced;

  addsub33 u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .sum (add_sum)
  );

  assign mul_high = !op_q[2] && (op_q != OP_MUL);
  assign mul_acc  = lo[0] ? add_sum : {1'b0, hi};

  always_comb begin
    if (op_q == OP_MUL)     fix_raw = lo;
    else if (!op_q[2])      fix_raw = hi;
    else if (!op_q[1])      fix_raw = lo;
    else                    fix_raw = hi;

    add_x   = {1'b0, hi};
    add_y   = {1'b0, bm};
    add_sub = op_q[2];
    if (state == S_FIX) begin
      // High word of a 64-bit negate is ~hi + (lo == 0); adding all-ones cancels the +1 when lo != 0.
      add_x   = {33{mul_high && (lo != '0)}};
      add_y   = {1'b0, fix_raw};
      add_sub = 1'b1;
    end else if (op_q[2]) begin
      add_x   = {hi, lo[XLEN-1]};
    end
  end

  always_comb begin
    a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    case (bus.op)
      OP_MULH, OP_DIV:   neg_next = bus.a[XLEN-1] ^ bus.b[XLEN-1];
      OP_MULHSU, OP_REM: neg_next = bus.a[XLEN-1];
      default:           neg_next = 1'b0;
    endcase
    div0   = bus.op[2] && (bus.b == '0);
    ovf    = bus.op[2] && !bus.op[0] && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    forced = bus.op[1] ? (div0 ? bus.a : '0) : (div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      bm         <= '0;
      op_q       <= OP_MUL;
      neg        <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            op_q     <= bus.op;
            cnt      <= '0;
            bm       <= magnitude(bus.b, b_signed);
            if (div0 || ovf) begin
              hi    <= forced;
              lo    <= forced;
              neg   <= 1'b0;
              state <= S_FIX;
            end else begin
              hi    <= '0;
              lo    <= magnitude(bus.a, a_signed);
              neg   <= neg_next;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            if (!add_sum[32]) begin
              hi <= add_sum[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= {hi[XLEN-2:0], lo[XLEN-1]};
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            hi <= mul_acc[32:1];
            lo <= {mul_acc[0], lo[XLEN-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          bus.result <= neg ? add_sum[XLEN-1:0] : fix_raw;
          state      <= S_DONE;
        end
        S_DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, ignored starts and reset abort.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a clock edge; start is sampled on the following edge.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                       input bit pulse_ignored);
    int n;
    bit seen;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_0013;
    check({tag, "_busy_on_accept"}, {31'd0, bus.busy}, 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        bus.start = pulse_ignored && (n == 5 || n == 20);
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    $display("op %-14s op=%0d result=%h latency=%0d", tag, o, bus.result, n);
  endtask

  initial begin
    int  k;
    bit  saw_done;
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    do_op("mul_7x-3",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
    do_op("mulh_min_sq",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 1'b0);
    do_op("mulhsu_m1",     OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
    do_op("mulhu_max",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    do_op("mulh_-2x3",     OP_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 34, 1'b0);
    do_op("div_-7/2",      OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 1'b0);
    do_op("rem_-7%2",      OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 1'b0);
    do_op("divu_100/7",    OP_DIVU,   32'd100,        32'd7,         32'd14,        34, 1'b0);
    do_op("remu_100%7",    OP_REMU,   32'd100,        32'd7,         32'd2,         34, 1'b0);
    do_op("divu_by0",      OP_DIVU,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 2,  1'b0);
    do_op("rem_by0",       OP_REM,    32'h0000_1234,  32'd0,         32'h0000_1234, 2,  1'b0);
    do_op("div_ovf",       OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b0);
    do_op("mul_ign_start", OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    do_op("divu_b2b",      OP_DIVU,   32'd100,        32'd7,         32'd14,        34, 1'b0);

    // Abort a DIV with an asynchronous reset in the middle of a cycle.
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'hFFFF_FFF9;
    bus.b     = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    saw_done = 1'b0;
    for (k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    $display("op %-14s aborted by reset, done seen=%0d", "div_abort", saw_done);

    do_op("div_after_rst", OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
